// File: rtl/ysyx_24090003_mem_arbiter.sv
// rtl/ysyx_24090003_mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
//
// Purpose:
//   Shares one CPU memory port between the IF and LS requesters, one
//   transaction at a time. LS normally wins a simultaneous request; directly
//   after an LS grant, IF wins instead so fetch cannot starve.
//
// Ports:
//   cpu_clk, cpu_rs        clock (rising edge), synchronous active-low reset
//   if_req_*/if_addr       IF request handshake and fetch address
//   if_resp_*/if_rdata     IF response pulse, data and timeout error
//   ls_req_*/ls_addr/ls_w* LS request handshake, address, store fields
//   ls_resp_*/ls_rdata     LS response pulse, data and timeout error
//   mem_req_*/mem_addr/... memory request driven from latched fields
//   mem_resp_valid/rdata   memory response
//
// Configuration:
//   ARB_TIMEOUT_EN  when defined, a WAIT state ends with an error response
//                   after TIMEOUT cycles without mem_resp_valid.

module ysyx_24090003_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                cpu_clk,
  input  logic                cpu_rs,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_IF, S_REQ_LS, S_WAIT_IF, S_WAIT_LS
  } state_e;

  state_e                state_q;
  logic                  last_ls_q;   // 1: last grant went to LS, 0: to IF
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;

  logic grant_ls, grant_if, idle, in_wait_if, in_wait_ls, in_wait;
  logic timeout_hit, done;

  assign idle       = (state_q == S_IDLE);
  assign in_wait_if = (state_q == S_WAIT_IF);
  assign in_wait_ls = (state_q == S_WAIT_LS);
  assign in_wait    = in_wait_if | in_wait_ls;

  assign grant_ls = ls_req_valid & (!if_req_valid | !last_ls_q);
  assign grant_if = if_req_valid & !grant_ls;

  // Readiness is masked during reset: an accept on a reset edge would be lost.
  assign ls_req_ready = cpu_rs & idle & grant_ls;
  assign if_req_ready = cpu_rs & idle & grant_if;

  assign mem_req_valid = (state_q == S_REQ_IF) | (state_q == S_REQ_LS);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt_q, wait_cnt_d;

  // Counter is zero on WAIT entry because every REQ cycle clears it.
  assign wait_cnt_d  = in_wait ? wait_cnt_q + 16'd1 : 16'd0;
  assign timeout_hit = in_wait & !mem_resp_valid & (wait_cnt_q == TO_LAST);

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rs) wait_cnt_q <= 16'd0;
    else         wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  // A real response in the same cycle as the timeout takes precedence.
  assign done = mem_resp_valid | timeout_hit;

  assign if_resp_valid = in_wait_if & done;
  assign if_resp_err   = in_wait_if & timeout_hit;
  assign if_rdata      = (in_wait_if & mem_resp_valid) ? mem_rdata : '0;
  assign ls_resp_valid = in_wait_ls & done;
  assign ls_resp_err   = in_wait_ls & timeout_hit;
  assign ls_rdata      = (in_wait_ls & mem_resp_valid) ? mem_rdata : '0;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rs) begin
      state_q   <= S_IDLE;
      last_ls_q <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_ls) begin
            addr_q    <= ls_addr;
            wen_q     <= ls_wen;
            wdata_q   <= ls_wdata;
            wmask_q   <= ls_wmask;
            last_ls_q <= 1'b1;
            state_q   <= S_REQ_LS;
          end else if (grant_if) begin
            addr_q    <= if_addr;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            last_ls_q <= 1'b0;
            state_q   <= S_REQ_IF;
          end
        end
        S_REQ_IF:  if (mem_req_ready) state_q <= S_WAIT_IF;
        S_REQ_LS:  if (mem_req_ready) state_q <= S_WAIT_LS;
        S_WAIT_IF: if (done) state_q <= S_IDLE;
        S_WAIT_LS: if (done) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

endmodule
